div_unit: RTL



---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 25 ++
 rtl/div_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 5;
  localparam logic [DIV_WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, subtract the divisor if it fits.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   shifted;
  logic         fits;
  logic [W-1:0] diff;

  // When the divisor fits the true difference is below 2^W, so W-bit wraparound is exact.
  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    fits    = (shifted >= {1'b0, dvs_i});
    diff    = shifted[W-1:0] - dvs_i;
    rem_o   = fits ? diff : shifted[W-1:0];
    quo_o   = {quo_i[W-2:0], fits};
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed restoring divider (quotient to lo, remainder to hi).
// Optional DIV_UNSIGNED_EN adds a div_unsigned input selecting DIVU semantics.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
  input  logic             div_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             zero_div,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               uns_q, uns_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               zero_div_q, zero_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic               start_uns;

`ifdef DIV_UNSIGNED_EN
  assign start_uns = div_unsigned;
`else
  assign start_uns = 1'b0;
`endif

  div_step #(.W(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    uns_d      = uns_q;
    done_d     = 1'b0;
    zero_div_d = zero_div_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      IDLE: begin
        if (div_start) begin
          if (divisor != '0) begin
            dvd_d      = dividend;
            dvs_d      = divisor;
            uns_d      = start_uns;
            zero_div_d = 1'b0;
            state_d    = PREP;
          end else begin
            zero_div_d = 1'b1;
            done_d     = 1'b1;
          end
        end
      end
      PREP: begin
        // Magnitudes are unsigned, so INT_MIN stays representable.
        if (uns_q) begin
          quo_d   = dvd_q;
          q_neg_d = 1'b0;
          r_neg_d = 1'b0;
        end else begin
          quo_d   = dvd_q[WIDTH-1] ? WIDTH'(-dvd_q) : dvd_q;
          dvs_d   = dvs_q[WIDTH-1] ? WIDTH'(-dvs_q) : dvs_q;
          q_neg_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
          r_neg_d = dvd_q[WIDTH-1];
        end
        rem_d   = '0;
        cnt_d   = CNT_W'(WIDTH - 1);
        state_d = RUN;
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = q_neg_q ? WIDTH'(-quo_q) : quo_q;
        hi_d    = r_neg_q ? WIDTH'(-rem_q) : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      uns_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_div_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      uns_q      <= uns_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      zero_div_q <= zero_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign zero_div = zero_div_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
